// File: rtl/instr_fetch.sv
// instr_fetch: sequential fetch/issue unit for the 8-bit core.
// Fetches one instruction byte at a time from instruction memory and holds it
// for the control decoder. It then steers the program counter from the
// jal/jr/beq outcome when downstream consumes the instruction.
//
// Ports:
//   clk, reset_n           rising-edge clock, async active-low reset
//   imem_req/addr          fetch request and address (address = pc)
//   imem_ack/rdata         memory response, taken only while fetching
//   instr_valid/instr      held instruction and its valid flag
//   opcode                 instr[7:4], drives the control decoder
//   stall                  downstream not ready, holds the instruction
//   br_taken, jr_target    beq compare result and jr register value
//   link_we/link_data      return-address write for jal (pc+1)
//   pc                     address of the held or fetched instruction
//   halted                 core stopped on opcode 4'b1111
//
// state | meaning
// IDLE  | leaving reset, fetch starts on next edge
// FETCH | request outstanding at pc, waiting for imem_ack
// ISSUE | instruction held for decode, consumed when stall=0
// HALT  | stopped until reset
module instr_fetch #(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  jr_target,
  output logic               link_we,
  output logic [ADDR_W-1:0]  link_data,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;

  localparam logic [3:0] OP_JR   = 4'hB;
  localparam logic [3:0] OP_BEQ  = 4'hC;
  localparam logic [3:0] OP_JAL  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t             state;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  pc_rel;
  logic [ADDR_W-1:0]  pc_nxt;
  logic [INSTR_W-1:0] instr_q;
  logic               consume;

  assign opcode  = instr_q[INSTR_W-1 -: 4];
  assign pc_inc  = pc_q + ADDR_W'(1);
  // Relative target: imm4 sign-extended, added to pc+1, wraps naturally.
  assign pc_rel  = pc_inc + {{(ADDR_W-4){instr_q[3]}}, instr_q[3:0]};
  assign consume = (state == ISSUE) && !stall;

  always_comb begin
    pc_nxt = pc_inc;
    case (opcode)
      OP_JAL:  pc_nxt = pc_rel;
      OP_JR:   pc_nxt = jr_target;
      OP_BEQ:  pc_nxt = br_taken ? pc_rel : pc_inc;
      default: pc_nxt = pc_inc;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (!stall) begin
            if (opcode == OP_HALT) begin
              state <= HALT;
            end else begin
              pc_q  <= pc_nxt;
              state <= FETCH;
            end
          end
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  // Status outputs decode the state register only, so reset clears them
  // asynchronously and no input reaches them combinationally.
  assign imem_req    = (state == FETCH);
  assign instr_valid = (state == ISSUE);
  assign halted      = (state == HALT);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  // The return address is written in the same cycle the jal is consumed.
  assign link_we     = consume && (opcode == OP_JAL);
  assign link_data   = pc_inc;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed program walk with a memory responder,
// an architectural reference model checked every cycle, and literal checks.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack = 1'b0;
  logic [7:0] imem_rdata = 8'h00;
  logic       instr_valid;
  logic [7:0] instr;
  logic [3:0] opcode;
  logic       stall = 1'b0;
  logic       br_taken = 1'b0;
  logic [7:0] jr_target = 8'h00;
  logic       link_we;
  logic [7:0] link_data;
  logic [7:0] pc;
  logic       halted;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  instr_fetch dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .opcode(opcode),
    .stall(stall), .br_taken(br_taken), .jr_target(jr_target),
    .link_we(link_we), .link_data(link_data),
    .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory and responder: mode 0 answers after lat wait cycles,
  // mode 1 sprays random acks, mode 2 holds a stale ack carrying a halt byte.
  logic [7:0] mem [256];
  int mode = 0;
  int lat = 0;
  int wcnt = 0;

  always @(posedge clk) begin
    #2;
    case (mode)
      0: begin
        if (imem_req) begin
          if (wcnt >= lat) begin
            imem_ack   = 1'b1;
            imem_rdata = mem[imem_addr];
            wcnt       = 0;
          end else begin
            imem_ack   = 1'b0;
            imem_rdata = 8'($urandom);
            wcnt++;
          end
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = 8'($urandom);
          wcnt       = 0;
        end
      end
      1: begin
        imem_ack   = 1'($urandom_range(0, 1));
        imem_rdata = 8'($urandom);
        wcnt       = 0;
      end
      default: begin
        imem_ack   = 1'b1;
        imem_rdata = 8'hF0;
        wcnt       = 0;
      end
    endcase
  end

  // Reference model: architectural pc/instruction plus which phase the unit
  // is in (starting, waiting on memory, holding an instruction, stopped).
  localparam int PH_START = 0, PH_MEM = 1, PH_HOLD = 2, PH_STOP = 3;
  int m_ph = PH_START;
  int m_pc = 0;
  int m_instr = 0;
  int m_op, m_simm;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ph = PH_START; m_pc = 0; m_instr = 0;
    end else if (m_ph == PH_START) begin
      m_ph = PH_MEM;
    end else if (m_ph == PH_MEM) begin
      if (imem_ack) begin m_instr = imem_rdata; m_ph = PH_HOLD; end
    end else if (m_ph == PH_HOLD && !stall) begin
      m_op   = m_instr / 16;
      m_simm = m_instr % 16;
      if (m_simm > 7) m_simm = m_simm - 16;
      m_ph = PH_MEM;
      if (m_op == 14)                   m_pc = (m_pc + 1 + m_simm + 256) % 256;
      else if (m_op == 11)              m_pc = jr_target;
      else if (m_op == 12 && br_taken)  m_pc = (m_pc + 1 + m_simm + 256) % 256;
      else if (m_op == 15)              m_ph = PH_STOP;
      else                              m_pc = (m_pc + 1) % 256;
    end
  end

  int exp_lw;
  always @(negedge clk) begin
    if (run) begin
      exp_lw = (m_ph == PH_HOLD && !stall && m_instr / 16 == 14) ? 1 : 0;
      chk("imem_req", imem_req, m_ph == PH_MEM);
      chk("instr_valid", instr_valid, m_ph == PH_HOLD);
      chk("halted", halted, m_ph == PH_STOP);
      chk("pc", pc, m_pc);
      chk("instr", instr, m_instr);
      chk("link_we", link_we, exp_lw);
      if (m_ph == PH_MEM)  chk("imem_addr", imem_addr, m_pc);
      if (m_ph == PH_HOLD) chk("opcode", opcode, m_instr / 16);
      if (exp_lw == 1)     chk("link_data", link_data, (m_pc + 1) % 256);
    end
  end

  int lw_cnt = 0;
  int lw_last = 0;
  always @(negedge clk) begin
    if (link_we) begin lw_cnt++; lw_last = link_data; end
  end

  task automatic wait_fetch_at(input int addr);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == addr) found = 1'b1;
    end
    chk($sformatf("fetch_at_%0h", addr), found, 1);
  endtask

  initial begin
    int n;
    foreach (mem[i]) mem[i] = 8'h00;
    mem[8'h00] = 8'h05; mem[8'h01] = 8'h12; mem[8'h02] = 8'hB0;
    mem[8'h10] = 8'hE3; mem[8'h14] = 8'h5C; mem[8'h15] = 8'hB0;
    mem[8'h20] = 8'hCE; mem[8'h1F] = 8'hB0; mem[8'h21] = 8'hB0;
    mem[8'h90] = 8'hB0; mem[8'hFF] = 8'h00; mem[8'h30] = 8'hF0;

    #2 reset_n = 1'b0;
    run = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk); chk("idle_req", imem_req, 0);
    @(negedge clk); chk("first_req", imem_req, 1); chk("first_addr", imem_addr, 8'h00);
    @(posedge clk); #1 lat = 2;
    @(negedge clk); chk("first_valid", instr_valid, 1); chk("first_opcode", opcode, 4'h0);
    @(negedge clk); chk("second_req", imem_req, 1); chk("second_addr", imem_addr, 8'h01);

    // slow memory plus two stalled issue cycles
    @(posedge clk); #1 stall = 1'b1;
    n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req) n++; else break;
    end
    chk("req_cycles", n, 3);
    chk("stall_valid1", instr_valid, 1); chk("stall_pc1", pc, 8'h01);
    @(negedge clk);
    chk("stall_valid2", instr_valid, 1); chk("stall_instr2", instr, 8'h12);
    @(posedge clk); #1 stall = 1'b0; lat = 0;
    wait_fetch_at(8'h02);
    @(posedge clk); #1 jr_target = 8'h10;

    // jal, br_taken on non-beq, beq taken / not taken
    wait_fetch_at(8'h10);
    wait_fetch_at(8'h14);
    chk("jal_pulses", lw_cnt, 1); chk("jal_link", lw_last, 8'h11);
    @(posedge clk); #1 br_taken = 1'b1;
    wait_fetch_at(8'h15);
    @(posedge clk); #1 br_taken = 1'b0; jr_target = 8'h20;
    wait_fetch_at(8'h20);
    @(posedge clk); #1 br_taken = 1'b1;
    wait_fetch_at(8'h1F);
    @(posedge clk); #1 br_taken = 1'b0; jr_target = 8'h20;
    wait_fetch_at(8'h20);
    wait_fetch_at(8'h21);

    // jr target sampled on the consume cycle
    @(posedge clk); #1 stall = 1'b1; jr_target = 8'h80;
    repeat (2) @(posedge clk);
    #1 jr_target = 8'h90;
    @(posedge clk); #1 stall = 1'b0;
    wait_fetch_at(8'h90);
    @(posedge clk); #1 jr_target = 8'hFF;
    wait_fetch_at(8'hFF);
    wait_fetch_at(8'h00);

    // reset mid-fetch at 0x42 with a stale ack around release
    @(posedge clk); #1 jr_target = 8'h42;
    wait_fetch_at(8'h02);
    @(posedge clk); #1 lat = 50;
    wait_fetch_at(8'h42);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b0;
    #1 chk("rst_req_drop", imem_req, 0); chk("rst_pc", pc, 8'h00);
    mode = 2;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1 mode = 0; lat = 0;
    wait_fetch_at(8'h00);
    @(negedge clk);
    chk("restart_instr", instr, 8'h05); chk("restart_halted", halted, 0);
    @(posedge clk); #1 jr_target = 8'h30;

    // halt, then random acks must not restart fetching
    wait_fetch_at(8'h30);
    @(negedge clk);
    @(negedge clk);
    chk("halt_flag", halted, 1); chk("halt_pc", pc, 8'h30); chk("halt_valid", instr_valid, 0);
    @(posedge clk); #1 mode = 1;
    repeat (10) begin
      @(negedge clk);
      chk("halt_no_req", imem_req, 0);
    end
    chk("total_link_pulses", lw_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Sequential instruction-fetch/issue unit for the 8-bit computer.
- Requests instruction bytes from instruction memory and presents the 4-bit opcode to the control decoder.
- Consumes the decoder's jump/branch outcomes (jal, jr, beq) to steer the program counter.
- Sits between instruction memory and the control/datapath; its opcode output drives the control decoder's instr input.

Parameters:
- ADDR_W, 8, program counter and instruction address width.
- INSTR_W, 8, instruction width; opcode = instr[7:4], imm4 = instr[3:0].
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  ADDR_W  fetch address; equals pc while imem_req=1.
- imem_ack  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  INSTR_W  instruction byte from memory.
- instr_valid  out  1  instr/opcode hold a live instruction.
- instr  out  INSTR_W  held instruction byte.
- opcode  out  4  instr[7:4]; feeds the control decoder.
- stall  in  1  downstream not ready; holds the current instruction.
- br_taken  in  1  beq compare result from the datapath.
- jr_target  in  ADDR_W  register value for jr.
- link_we  out  1  one-cycle pulse to write the return address.
- link_data  out  ADDR_W  return address (pc+1) for jal.
- pc  out  ADDR_W  address of the currently held or fetched instruction.
- halted  out  1  core stopped on opcode 4'b1111.

Behaviour:
- Reset (reset_n=0, async):
  - state=IDLE, pc=RESET_PC, instr=0.
  - imem_req, instr_valid, link_we and halted are all 0.
- FSM states: IDLE, FETCH, ISSUE, HALT.
- IDLE: moves to FETCH on the first rising edge after reset_n deasserts.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack=1: latch imem_rdata into instr and go to ISSUE.
  - Memory latency is unbounded; imem_req stays high until ack.
- ISSUE:
  - instr_valid=1, opcode=instr[7:4].
  - While stall=1: hold instr and pc; br_taken and jr_target are ignored.
  - Consume cycle is the cycle with stall=0. In that cycle, next pc is:
    - 4'b1110 jal: pc+1+sext(imm4). link_we=1 and link_data=pc+1 in that same cycle.
    - 4'b1011 jr: jr_target.
    - 4'b1100 beq: pc+1+sext(imm4) if br_taken=1, else pc+1.
    - 4'b1111: pc unchanged; go to HALT.
    - any other opcode: pc+1.
  - Non-halt: go to FETCH next cycle. Issue rate is therefore at most 1 instruction per 2 cycles with a zero-wait memory.
- HALT:
  - halted=1, instr_valid=0, imem_req=0.
  - Stays in HALT until reset; stall and imem_ack are ignored.
- Arithmetic:
  - All pc math is modulo 2^ADDR_W: 8'hFF+1 wraps to 8'h00.
  - sext(imm4) spans -8..+7. Branch/jal targets also wrap (e.g. pc=8'h02, imm4=4'hA gives 8'hFD).
- Boundary conditions:
  - imem_ack outside FETCH is ignored, as is imem_rdata without ack.
  - br_taken on a non-beq opcode is ignored.
  - link_we is never asserted for anything other than a consumed jal.
  - Async reset mid-FETCH drops imem_req immediately; an ack in the following cycles is ignored until FETCH is re-entered.
  - Reset mid-ISSUE discards the held instruction and produces no link_we pulse.
  - instr_valid is registered (state-decoded) and never combinational from inputs.

Test Plan:
- Reset release, zero-wait memory returning 8'h05 at 0x00 → imem_req high the 2nd cycle after release with addr 0x00; instr_valid next cycle with opcode 4'h0; then fetch at 0x01.
- Memory ack delayed 3 cycles with stall=1 for 2 ISSUE cycles → imem_req held 3 cycles; instr and pc frozen; pc advances only after stall drops.
- jal 8'hE3 at pc=0x10 → link_we single pulse, link_data=0x11; next imem_addr=0x14. beq 8'hCE at pc=0x20: br_taken=1 gives 0x1F, br_taken=0 gives 0x21.
- jr 8'hB0 with jr_target=0x80 and stall=1, jr_target changed to 0x90 before stall drops → next fetch at 0x90 (value sampled on the consume cycle).
- pc=0xFF running add 8'h00 → next fetch at 0x00. Opcode 8'hF0 → halted=1, imem_req remains 0 for 10 cycles despite random imem_ack.
- Assert reset_n=0 mid-FETCH at pc=0x42 → imem_req drops asynchronously; pc=0x00 and restart at 0x00 after release; a stale ack during reset has no effect.
